alu_pipe: RTL and testbench

//  Parametrised 2-stage pipelined integer ALU for the superscalar execute lanes, one instance per lane.

---
 rtl/alu_pipe.sv | 190 +++++++++++++++++++
 tb/tb_alu_pipe.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined integer ALU for one superscalar execute lane.
//
// Stage 1 captures operands, op, shift amount and tag on an accepted input.
// Stage 2 captures the computed result, branch outcome, illegal flag and tag.
// A valid/ready handshake on both sides lets the pipe stall without losing ops.
// flush synchronously kills everything in flight.
//
// Optional feature macro: ALU_UNSIGNED_CMP_EN
//   defined   -> op14 sltu and op15 bltu are implemented
//   undefined -> op14/op15 are reported as illegal
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   flush             kill all in-flight ops at the next edge
//   in_valid/in_ready input handshake
//   in_rs1, in_rs2    operands A and B
//   in_op             4-bit op code
//   in_shamt          shift amount
//   in_tag            tag returned unchanged with the result
//   out_valid/ready   output handshake
//   out_result        result word
//   out_branch        branch taken (branch ops only)
//   out_illegal       op not supported in this build
//   out_tag           tag of the presented result

module alu_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 6,
    localparam int unsigned SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_rs1,
    input  logic [WIDTH-1:0] in_rs2,
    input  logic [3:0]       in_op,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_branch,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [3:0] {
        OpAdd  = 4'd0,
        OpSub  = 4'd1,
        OpSll  = 4'd2,
        OpSla  = 4'd3,
        OpSrl  = 4'd4,
        OpSra  = 4'd5,
        OpXor  = 4'd6,
        OpOr   = 4'd7,
        OpAnd  = 4'd8,
        OpBeq  = 4'd9,
        OpBne  = 4'd10,
        OpBlt  = 4'd11,
        OpBge  = 4'd12,
        OpSlt  = 4'd13,
        OpSltu = 4'd14,
        OpBltu = 4'd15
    } op_e;

    // Stage 1 state
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    op_e              s1_op;
    logic [SHW-1:0]   s1_shamt;
    logic [TAG_W-1:0] s1_tag;

    // Stage 2 state (drives the outputs directly)
    logic             s2_valid;
    logic [WIDTH-1:0] s2_result;
    logic             s2_branch;
    logic             s2_illegal;
    logic [TAG_W-1:0] s2_tag;

    logic s2_adv;
    logic s1_adv;
    logic in_fire;

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = s1_valid && s2_adv;
    assign in_ready = !s1_valid || s2_adv;
    // flush blocks acceptance even though in_ready may be high
    assign in_fire  = in_valid && in_ready && !flush;

    // Single subtractor shared by sub, equality and both compare flavours.
    logic [WIDTH:0]   sub_full;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] sum;
    logic             eq;
    logic             lt_s;
    logic             lt_u;
    logic [WIDTH-1:0] sra_res;

    assign sub_full = {1'b0, s1_a} + {1'b0, ~s1_b} + {{WIDTH{1'b0}}, 1'b1};
    assign diff     = sub_full[WIDTH-1:0];
    assign sum      = s1_a + s1_b;
    assign eq       = (diff == '0);
    // Differing signs: A is less exactly when A is negative; otherwise the
    // difference cannot overflow and its sign decides.
    assign lt_s     = (s1_a[WIDTH-1] ^ s1_b[WIDTH-1]) ? s1_a[WIDTH-1] : diff[WIDTH-1];
    // No carry out of A + ~B + 1 means a borrow, i.e. A < B unsigned.
    assign lt_u     = !sub_full[WIDTH];
    assign sra_res  = $unsigned($signed(s1_a) >>> s1_shamt);

    logic [WIDTH-1:0] res_d;
    logic             br_d;
    logic             ill_d;

    always_comb begin
        res_d = '0;
        br_d  = 1'b0;
        ill_d = 1'b0;
        case (s1_op)
            OpAdd:         res_d = sum;
            OpSub:         res_d = diff;
            OpSll, OpSla:  res_d = s1_a << s1_shamt;
            OpSrl:         res_d = s1_a >> s1_shamt;
            OpSra:         res_d = sra_res;
            OpXor:         res_d = s1_a ^ s1_b;
            OpOr:          res_d = s1_a | s1_b;
            OpAnd:         res_d = s1_a & s1_b;
            OpBeq:         br_d  = eq;
            OpBne:         br_d  = !eq;
            OpBlt:         br_d  = lt_s;
            OpBge:         br_d  = !lt_s;
            OpSlt:         res_d = {{(WIDTH-1){1'b0}}, lt_s};
`ifdef ALU_UNSIGNED_CMP_EN
            OpSltu:        res_d = {{(WIDTH-1){1'b0}}, lt_u};
            OpBltu:        br_d  = lt_u;
`endif
            default:       ill_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_op      <= OpAdd;
            s1_shamt   <= '0;
            s1_tag     <= '0;
            s2_valid   <= 1'b0;
            s2_result  <= '0;
            s2_branch  <= 1'b0;
            s2_illegal <= 1'b0;
            s2_tag     <= '0;
        end else begin
            if (flush) begin
                s1_valid <= 1'b0;
            end else if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (in_fire) begin
                s1_a     <= in_rs1;
                s1_b     <= in_rs2;
                s1_op    <= op_e'(in_op);
                s1_shamt <= in_shamt;
                s1_tag   <= in_tag;
            end

            if (flush) begin
                s2_valid <= 1'b0;
            end else if (s2_adv) begin
                s2_valid <= s1_valid;
            end
            if (s1_adv && !flush) begin
                s2_result  <= res_d;
                s2_branch  <= br_d;
                s2_illegal <= ill_d;
                s2_tag     <= s1_tag;
            end
        end
    end

    assign out_valid   = s2_valid;
    assign out_result  = s2_result;
    assign out_branch  = s2_branch;
    assign out_illegal = s2_illegal;
    assign out_tag     = s2_tag;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=32, TAG_W=6). The driver pushes the
// expected response when the DUT accepts an op; an independent monitor pops
// and compares on every output transfer and checks that a stalled output
// holds steady.

module tb_alu_pipe;

    localparam int W  = 32;
    localparam int TW = 6;

    typedef struct packed {
        logic [W-1:0]  result;
        logic          branch;
        logic          illegal;
        logic [TW-1:0] tag;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_rs1 = '0;
    logic [W-1:0]  in_rs2 = '0;
    logic [3:0]    in_op = '0;
    logic [4:0]    in_shamt = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_result;
    logic          out_branch;
    logic          out_illegal;
    logic [TW-1:0] out_tag;

    alu_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_op       (in_op),
        .in_shamt    (in_shamt),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_branch  (out_branch),
        .out_illegal (out_illegal),
        .out_tag     (out_tag)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   ready_rand = 1'b0;
    bit   held = 1'b0;
    exp_t held_v;
    logic [TW-1:0] tag_ctr = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain arithmetic on the op semantics.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [4:0] sh,
                                   input logic [TW-1:0] tag);
        exp_t e;
        e.result  = '0;
        e.branch  = 1'b0;
        e.illegal = 1'b0;
        e.tag     = tag;
        case (op)
            4'd0:  e.result = a + b;
            4'd1:  e.result = a - b;
            4'd2,
            4'd3:  e.result = a << sh;
            4'd4:  e.result = a >> sh;
            4'd5:  e.result = $unsigned($signed(a) >>> sh);
            4'd6:  e.result = a ^ b;
            4'd7:  e.result = a | b;
            4'd8:  e.result = a & b;
            4'd9:  e.branch = (a == b);
            4'd10: e.branch = (a != b);
            4'd11: e.branch = ($signed(a) < $signed(b));
            4'd12: e.branch = ($signed(a) >= $signed(b));
            4'd13: e.result = {31'b0, ($signed(a) < $signed(b))};
`ifdef ALU_UNSIGNED_CMP_EN
            4'd14: e.result = {31'b0, (a < b)};
            4'd15: e.branch = (a < b);
`else
            4'd14,
            4'd15: e.illegal = 1'b1;
`endif
            default: e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    // Output ready driver: random or forced.
    initial begin
        forever begin
            @(negedge clk);
            if (ready_rand) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic set_ready(input bit rnd, input logic val);
        ready_rand = rnd;
        if (!rnd) out_ready = val;
    endtask

    // Monitor: samples just before each rising edge.
    initial begin
        exp_t cur;
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                held = 1'b0;
            end else begin
                cur = {out_result, out_branch, out_illegal, out_tag};
                if (held) check("stall hold", 64'(cur), 64'(held_v));
                if (flush) begin
                    held = 1'b0;
                end else if (out_valid && out_ready) begin
                    held = 1'b0;
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected output: got 0x%0h, expected none", cur);
                    end else begin
                        e = q.pop_front();
                        check("result/branch/illegal/tag", 64'(cur), 64'(e));
                    end
                end else if (out_valid) begin
                    held   = 1'b1;
                    held_v = cur;
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    // Present one op for a single cycle; caller starts at a falling edge.
    task automatic try_send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [4:0] sh, input logic [TW-1:0] tag, input exp_t e,
                            output bit acc);
        in_valid = 1'b1;
        in_op    = op;
        in_rs1   = a;
        in_rs2   = b;
        in_shamt = sh;
        in_tag   = tag;
        #4;
        acc = in_ready && !flush;
        if (acc) q.push_back(e);
        @(negedge clk);
    endtask

    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] sh, input logic [TW-1:0] tag, input exp_t e);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 200) begin
            try_send(op, a, b, sh, tag, e, acc);
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send timeout: got no accept, expected accept within 200 cycles");
        end
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] sp [5];
        sp[0] = 32'h0;
        sp[1] = 32'h1;
        sp[2] = 32'hFFFF_FFFF;
        sp[3] = 32'h7FFF_FFFF;
        sp[4] = 32'h8000_0000;
        if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
        return $urandom();
    endfunction

    task automatic send_rand();
        logic [3:0]    op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [4:0]    sh;
        op = 4'($urandom_range(0, 15));
        a  = rand_word();
        b  = ($urandom_range(0, 3) == 0) ? a : rand_word();
        sh = 5'($urandom_range(0, 31));
        tag_ctr++;
        send(op, a, b, sh, tag_ctr, model(op, a, b, sh, tag_ctr));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(q.size()), 64'd0);
    endtask

    // Directed vectors with hand-derived expectations.
    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [4:0]   sh;
        logic [W-1:0] res;
        logic         br;
        logic         ill;
    } vec_t;

    vec_t vecs[$];

    initial begin
        exp_t e;
        bit   acc;
        int   idx;
        logic [3:0]   bp_op [3];
        logic [W-1:0] bp_a  [3];
        logic [W-1:0] bp_b  [3];

        vecs.push_back('{4'd11, 32'hFFFF_FFFF, 32'h1,         5'd0,  32'h0,         1'b1, 1'b0});
        vecs.push_back('{4'd11, 32'h7FFF_FFFF, 32'h8000_0000, 5'd0,  32'h0,         1'b0, 1'b0});
        vecs.push_back('{4'd12, 32'h8000_0000, 32'h7FFF_FFFF, 5'd0,  32'h0,         1'b0, 1'b0});
        vecs.push_back('{4'd5,  32'h8000_0000, 32'h0,         5'd31, 32'hFFFF_FFFF, 1'b0, 1'b0});
        vecs.push_back('{4'd4,  32'h8000_0000, 32'h0,         5'd31, 32'h1,         1'b0, 1'b0});
        vecs.push_back('{4'd3,  32'h1,         32'h0,         5'd31, 32'h8000_0000, 1'b0, 1'b0});
        vecs.push_back('{4'd4,  32'h1234_5678, 32'h0,         5'd0,  32'h1234_5678, 1'b0, 1'b0});
        vecs.push_back('{4'd1,  32'h0,         32'h1,         5'd0,  32'hFFFF_FFFF, 1'b0, 1'b0});
        vecs.push_back('{4'd13, 32'h8000_0000, 32'h1,         5'd0,  32'h1,         1'b0, 1'b0});
        vecs.push_back('{4'd9,  32'h5,         32'h5,         5'd0,  32'h0,         1'b1, 1'b0});
        vecs.push_back('{4'd10, 32'h5,         32'h5,         5'd0,  32'h0,         1'b0, 1'b0});
`ifdef ALU_UNSIGNED_CMP_EN
        vecs.push_back('{4'd14, 32'h1,         32'hFFFF_FFFF, 5'd0,  32'h1,         1'b0, 1'b0});
        vecs.push_back('{4'd15, 32'h1,         32'hFFFF_FFFF, 5'd0,  32'h0,         1'b1, 1'b0});
`else
        vecs.push_back('{4'd14, 32'h1,         32'hFFFF_FFFF, 5'd0,  32'h0,         1'b0, 1'b1});
        vecs.push_back('{4'd15, 32'h1,         32'hFFFF_FFFF, 5'd0,  32'h0,         1'b0, 1'b1});
`endif

        // Reset state
        #12 rst = 1'b0;
        @(negedge clk);
        #4;
        check("reset out_valid",   64'(out_valid),   64'd0);
        check("reset out_result",  64'(out_result),  64'd0);
        check("reset out_branch",  64'(out_branch),  64'd0);
        check("reset out_illegal", 64'(out_illegal), 64'd0);
        check("reset out_tag",     64'(out_tag),     64'd0);
        check("reset in_ready",    64'(in_ready),    64'd1);
        @(negedge clk);

        // Latency: add wraps to zero, tag 5, visible two edges after accept
        set_ready(1'b0, 1'b1);
        e = '{result: 32'h0, branch: 1'b0, illegal: 1'b0, tag: 6'd5};
        send(4'd0, 32'hFFFF_FFFF, 32'h1, 5'd0, 6'd5, e);
        #4;
        check("latency not early", 64'(out_valid), 64'd0);
        @(negedge clk);
        #4;
        check("latency out_valid", 64'(out_valid), 64'd1);
        check("latency result",    64'(out_result), 64'd0);
        check("latency tag",       64'(out_tag), 64'd5);
        check("latency illegal",   64'(out_illegal), 64'd0);
        @(negedge clk);

        // Directed vectors, back to back
        foreach (vecs[i]) begin
            tag_ctr++;
            e = '{result: vecs[i].res, branch: vecs[i].br, illegal: vecs[i].ill, tag: tag_ctr};
            send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, tag_ctr, e);
        end
        wait_drain();

        // Backpressure: three ops offered, consumer stalled for four cycles
        set_ready(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            bp_op[i] = 4'(i * 5);
            bp_a[i]  = $urandom();
            bp_b[i]  = $urandom();
        end
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            tag_ctr = 6'(40 + idx);
            try_send(bp_op[idx], bp_a[idx], bp_b[idx], 5'd3, tag_ctr,
                     model(bp_op[idx], bp_a[idx], bp_b[idx], 5'd3, tag_ctr), acc);
            if (acc) idx++;
        end
        check("accepted under stall", 64'(idx), 64'd2);
        #4;
        check("in_ready under stall", 64'(in_ready), 64'd0);
        check("out_valid under stall", 64'(out_valid), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        set_ready(1'b0, 1'b1);
        while (idx < 3) begin
            tag_ctr = 6'(40 + idx);
            send(bp_op[idx], bp_a[idx], bp_b[idx], 5'd3, tag_ctr,
                 model(bp_op[idx], bp_a[idx], bp_b[idx], 5'd3, tag_ctr));
            idx++;
        end
        wait_drain();

        // Flush with a full pipe and a competing input
        set_ready(1'b0, 1'b0);
        send_rand();
        send_rand();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_op    = 4'd0;
        in_tag   = 6'd63;
        #4;
        q.delete();
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        #4;
        check("flush out_valid", 64'(out_valid), 64'd0);
        check("flush in_ready",  64'(in_ready),  64'd1);
        @(negedge clk);
        set_ready(1'b0, 1'b1);
        repeat (5) @(negedge clk);

        // Asynchronous reset with ops in flight
        set_ready(1'b0, 1'b0);
        send_rand();
        send_rand();
        #1 rst = 1'b1;
        #1;
        check("async reset out_valid", 64'(out_valid), 64'd0);
        check("async reset in_ready",  64'(in_ready),  64'd1);
        q.delete();
        held = 1'b0;
        #1 rst = 1'b0;
        @(negedge clk);
        set_ready(1'b0, 1'b1);
        repeat (4) @(negedge clk);

        // Random traffic with random backpressure and occasional flushes
        set_ready(1'b1, 1'b0);
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                flush    = 1'b1;
                in_valid = 1'($urandom_range(0, 1));
                #4;
                q.delete();
                @(negedge clk);
                flush    = 1'b0;
                in_valid = 1'b0;
            end else if (r < 25) begin
                @(negedge clk);
            end else begin
                send_rand();
            end
        end
        set_ready(1'b0, 1'b1);
        wait_drain();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
